// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [2:0] SIZE_BYTE = 3'b000;
   localparam logic [2:0] SIZE_HALF = 3'b001;
   localparam logic [2:0] SIZE_WORD = 3'b010;

   // Number of bytes touched by an access; illegal sizes count as one byte
   // (they are flagged as errors separately).
   function automatic logic [2:0] size_bytes(input logic [2:0] size);
      case (size)
         SIZE_HALF: return 3'd2;
         SIZE_WORD: return 3'd4;
         default:   return 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts just after the
// previous winner and wraps, so every requester is served within NUM_REQ grants.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     last_grant,
   output logic [NUM_REQ-1:0] grant
);

   logic found;
   int   idx;

   // Scan offsets 1..NUM_REQ from the last winner; first active request wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_grant) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises accesses from NUM_REQ requesters onto a single-ported data RAM.
// One transaction at a time: accept (IDLE), strobe RAM (ISSUE), respond (RESP).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int MEM_BYTES = 32004
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ-1:0]      req_we,
   input  logic [3*NUM_REQ-1:0]    req_size,
   input  logic [32*NUM_REQ-1:0]   req_addr,
   input  logic [32*NUM_REQ-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic                    rsp_err,
   output logic [31:0]             rsp_rdata,
   output logic                    mem_we,
   output logic                    mem_re,
   output logic [2:0]              mem_size,
   output logic [31:0]             mem_addr,
   output logic [31:0]             mem_wdata,
   input  logic [31:0]             mem_rdata
);

   localparam int IDW = $clog2(NUM_REQ);

   state_t            state_reg, state_next;
   logic [IDW-1:0]    last_grant_reg;
   logic [IDW-1:0]    id_reg;
   logic              we_reg;
   logic [2:0]        size_reg;
   logic [31:0]       addr_reg;
   logic [31:0]       wdata_reg;
   logic              err_reg;

   logic [NUM_REQ-1:0] grant;
   logic [IDW-1:0]     win_id;
   logic               sel_we;
   logic [2:0]         sel_size;
   logic [31:0]        sel_addr;
   logic [31:0]        sel_wdata;
   logic               sel_err;
   logic               accept;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
      .req        (req_valid),
      .last_grant (last_grant_reg),
      .grant      (grant)
   );

   // Mux the winning requester's fields and classify the access.
   always_comb begin
      win_id    = '0;
      sel_we    = 1'b0;
      sel_size  = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            win_id    = IDW'(i);
            sel_we    = req_we[i];
            sel_size  = req_size[3*i +: 3];
            sel_addr  = req_addr[32*i +: 32];
            sel_wdata = req_wdata[32*i +: 32];
         end
      end
      sel_err = 1'b0;
      if (sel_size > SIZE_WORD)
         sel_err = 1'b1;
      else if (sel_size == SIZE_HALF && sel_addr[0])
         sel_err = 1'b1;
      else if (sel_size == SIZE_WORD && sel_addr[1:0] != 2'b00)
         sel_err = 1'b1;
      // 33-bit sum so addresses near 2^32 cannot wrap into range.
      if (({1'b0, sel_addr} + 33'(size_bytes(sel_size))) > 33'(MEM_BYTES))
         sel_err = 1'b1;
   end

   assign accept = (state_reg == IDLE) && (|req_valid) && !reset;

   // Next-state logic: IDLE waits for a request, ISSUE and RESP last one cycle each.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (|req_valid) state_next = ISSUE;
         ISSUE:   state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register, round-robin pointer and transaction latches.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         last_grant_reg <= IDW'(NUM_REQ - 1);
         id_reg         <= '0;
         we_reg         <= 1'b0;
         size_reg       <= '0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         err_reg        <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            last_grant_reg <= win_id;
            id_reg         <= win_id;
            we_reg         <= sel_we;
            size_reg       <= sel_size;
            addr_reg       <= sel_addr;
            wdata_reg      <= sel_wdata;
            err_reg        <= sel_err;
         end
      end
   end

   // Outputs decode from state; everything is held at zero while reset is high
   // so a reset landing in ISSUE cannot strobe the RAM.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      rsp_err   = 1'b0;
      rsp_rdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_size  = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (!reset) begin
         case (state_reg)
            IDLE: req_ready = grant;
            ISSUE: begin
               if (!err_reg) begin
                  mem_we    = we_reg;
                  mem_re    = !we_reg;
                  mem_size  = size_reg;
                  mem_addr  = addr_reg;
                  mem_wdata = wdata_reg;
               end
            end
            RESP: begin
               rsp_valid = NUM_REQ'(1) << id_reg;
               rsp_err   = err_reg;
               if (!err_reg && !we_reg)
                  rsp_rdata = mem_rdata;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed RAM model.
module tb_dmem_arbiter;

   localparam int NUM_REQ   = 2;
   localparam int MEM_BYTES = 32004;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    req_we;
   logic [3*NUM_REQ-1:0]  req_size;
   logic [32*NUM_REQ-1:0] req_addr;
   logic [32*NUM_REQ-1:0] req_wdata;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic                  rsp_err;
   logic [31:0]           rsp_rdata;
   logic                  mem_we;
   logic                  mem_re;
   logic [2:0]            mem_size;
   logic [31:0]           mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.NUM_REQ(NUM_REQ), .MEM_BYTES(MEM_BYTES)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_err   (rsp_err),
      .rsp_rdata (rsp_rdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_size  (mem_size),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // RAM model: little-endian bytes, registered zero-extended read.
   // Reset reloads a known image: word 0x10 = DEADBEEF, word 32000 = 44332211.
   logic [7:0] ram [0:MEM_BYTES-1];
   always @(posedge clk) begin
      int a;
      a = int'(mem_addr);
      if (reset) begin
         for (int i = 0; i < MEM_BYTES; i++) ram[i] <= 8'h00;
         ram[16] <= 8'hEF; ram[17] <= 8'hBE; ram[18] <= 8'hAD; ram[19] <= 8'hDE;
         ram[32000] <= 8'h11; ram[32001] <= 8'h22; ram[32002] <= 8'h33; ram[32003] <= 8'h44;
         mem_rdata <= '0;
      end else begin
         if (mem_we) begin
            ram[a] <= mem_wdata[7:0];
            if (mem_size != 3'b000) ram[a+1] <= mem_wdata[15:8];
            if (mem_size == 3'b010) begin
               ram[a+2] <= mem_wdata[23:16];
               ram[a+3] <= mem_wdata[31:24];
            end
         end
         if (mem_re) begin
            case (mem_size)
               3'b000:  mem_rdata <= {24'h0, ram[a]};
               3'b001:  mem_rdata <= {16'h0, ram[a+1], ram[a]};
               default: mem_rdata <= {ram[a+3], ram[a+2], ram[a+1], ram[a]};
            endcase
         end
      end
   end

   typedef struct {
      int          r;
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   task automatic drive(input int r, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
      req_we[r]            = we;
      req_size[3*r +: 3]   = size;
      req_addr[32*r +: 32] = addr;
      req_wdata[32*r +: 32] = wdata;
   endtask

   // Full accept/issue/respond sequence for one vector, checking every cycle.
   task automatic run_txn(input int n, input vec_t v);
      int w;
      logic [NUM_REQ-1:0] one;
      one = NUM_REQ'(1) << v.r;
      @(negedge clk);
      drive(v.r, v.we, v.size, v.addr, v.wdata);
      req_valid = one;
      #1;
      w = 0;
      while (!req_ready[v.r] && w < 10) begin
         @(negedge clk); #1; w++;
      end
      chk($sformatf("v%0d ready", n), 32'(req_ready), 32'(one));
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk($sformatf("v%0d issue_ready", n), 32'(req_ready), 32'h0);
      chk($sformatf("v%0d mem_we", n), 32'(mem_we), 32'(!v.err && v.we));
      chk($sformatf("v%0d mem_re", n), 32'(mem_re), 32'(!v.err && !v.we));
      chk($sformatf("v%0d mem_addr", n), mem_addr, v.err ? 32'h0 : v.addr);
      chk($sformatf("v%0d mem_size", n), 32'(mem_size), v.err ? 32'h0 : 32'(v.size));
      chk($sformatf("v%0d mem_wdata", n), mem_wdata, v.err ? 32'h0 : v.wdata);
      @(negedge clk);
      chk($sformatf("v%0d rsp_valid", n), 32'(rsp_valid), 32'(one));
      chk($sformatf("v%0d rsp_err", n), 32'(rsp_err), 32'(v.err));
      chk($sformatf("v%0d rsp_rdata", n), rsp_rdata, v.rdata);
      $display("txn %0d: req%0d we=%0b size=%0d addr=%h wdata=%h -> err=%0b rdata=%h",
               n, v.r, v.we, v.size, v.addr, v.wdata, rsp_err, rsp_rdata);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int w;
      logic [NUM_REQ-1:0] exp_g;

      //        r  we    size    addr           wdata         err   rdata
      vecs[0]  = '{0, 1'b0, 3'b010, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
      vecs[1]  = '{1, 1'b1, 3'b000, 32'h13,       32'h000000A5, 1'b0, 32'h0};
      vecs[2]  = '{1, 1'b0, 3'b010, 32'h10,       32'h0,        1'b0, 32'hA5ADBEEF};
      vecs[3]  = '{0, 1'b0, 3'b001, 32'h12,       32'h0,        1'b0, 32'h0000A5AD};
      vecs[4]  = '{0, 1'b0, 3'b000, 32'h11,       32'h0,        1'b0, 32'h000000BE};
      vecs[5]  = '{0, 1'b0, 3'b010, 32'h12,       32'h0,        1'b1, 32'h0};
      vecs[6]  = '{1, 1'b0, 3'b011, 32'h10,       32'h0,        1'b1, 32'h0};
      vecs[7]  = '{0, 1'b0, 3'b010, 32'd32004,    32'h0,        1'b1, 32'h0};
      vecs[8]  = '{1, 1'b0, 3'b010, 32'd32000,    32'h0,        1'b0, 32'h44332211};
      vecs[9]  = '{0, 1'b0, 3'b001, 32'h11,       32'h0,        1'b1, 32'h0};
      vecs[10] = '{0, 1'b1, 3'b010, 32'h20,       32'h12345678, 1'b0, 32'h0};
      vecs[11] = '{1, 1'b1, 3'b010, 32'h21,       32'hFFFFFFFF, 1'b1, 32'h0};
      vecs[12] = '{1, 1'b0, 3'b010, 32'h20,       32'h0,        1'b0, 32'h12345678};
      vecs[13] = '{0, 1'b0, 3'b001, 32'd32003,    32'h0,        1'b1, 32'h0};

      reset     = 1'b1;
      req_valid = '0;
      req_we    = '0;
      req_size  = '0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset req_ready", 32'(req_ready), 32'h0);
      chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset mem_strobe", 32'({mem_we, mem_re}), 32'h0);
      chk("reset mem_addr", mem_addr, 32'h0);

      for (int i = 0; i < 14; i++) run_txn(i, vecs[i]);

      // Contention: both requesters hold valid; grants must alternate 0,1,...
      do_reset();
      drive(0, 1'b0, 3'b010, 32'h10, 32'h0);
      drive(1, 1'b0, 3'b010, 32'h10, 32'h0);
      req_valid = 2'b11;
      for (int i = 0; i < 6; i++) begin
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         w = 0;
         while (req_ready == '0 && w < 10) begin
            @(negedge clk); #1; w++;
         end
         chk($sformatf("contend grant %0d", i), 32'(req_ready), 32'(exp_g));
         @(negedge clk);
         @(negedge clk);
         chk($sformatf("contend rsp %0d", i), 32'(rsp_valid), 32'(exp_g));
         chk($sformatf("contend rdata %0d", i), rsp_rdata, 32'hDEADBEEF);
         $display("txn contend %0d: grant=%b rsp=%b rdata=%h", i, exp_g, rsp_valid, rsp_rdata);
         @(negedge clk);
      end
      req_valid = '0;

      // Reset landing in ISSUE drops the transaction.
      @(negedge clk);
      drive(1, 1'b0, 3'b010, 32'h10, 32'h0);
      req_valid = 2'b10;
      #1;
      w = 0;
      while (!req_ready[1] && w < 10) begin
         @(negedge clk); #1; w++;
      end
      chk("rst txn ready", 32'(req_ready), 32'h2);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("rst pre mem_re", 32'(mem_re), 32'h1);
      reset = 1'b1;
      #1;
      chk("rst during mem_re", 32'(mem_re), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst after rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst after mem", 32'({mem_we, mem_re}), 32'h0);
      chk("rst after ready", 32'(req_ready), 32'h0);
      chk("rst after rdata", rsp_rdata, 32'h0);
      @(negedge clk);
      chk("rst no late rsp", 32'(rsp_valid), 32'h0);
      drive(0, 1'b0, 3'b010, 32'h10, 32'h0);
      drive(1, 1'b0, 3'b010, 32'h10, 32'h0);
      req_valid = 2'b11;
      #1;
      chk("rst next grant", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("rst next mem_re", 32'(mem_re), 32'h1);
      @(negedge clk);
      chk("rst next rsp", 32'(rsp_valid), 32'h1);
      chk("rst next rdata", rsp_rdata, 32'hDEADBEEF);
      $display("txn reset-recover: rsp=%b err=%0b rdata=%h", rsp_valid, rsp_err, rsp_rdata);

      @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
